freq_div_monitor: RTL and testbench

Receive-side checker for the divided clocks produced by the team's frequency dividers. It samples a divided-clock signal that is synchronous to the system clock and measures each period and high time in clk cycles. It reports each complete measurement, declares lock after a run of cycles matching the expected ratio, and flags mismatches or a stalled input. It sits beside any divider instance as a built-in self-check and a bench-reusable monitor.

---
 rtl/freq_div_monitor.sv | 119 +++++++++++
 tb/tb_freq_div_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_div_monitor.sv
// Receive-side monitor for a clk-synchronous divided clock: measures period and
// high time, reports each period, tracks lock against DIV/EXP_HIGH, flags faults.
module freq_div_monitor #(
   parameter int unsigned DIV        = 6,
   parameter int unsigned EXP_HIGH   = 3,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned TIMEOUT    = 24,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freq_in,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             meas_valid,
   output logic             locked,
   output logic             err
);

   localparam int unsigned MATCH_W = 4;

   localparam logic [CNT_W-1:0]   DIV_C      = CNT_W'(DIV);
   localparam logic [CNT_W-1:0]   EXP_HIGH_C = CNT_W'(EXP_HIGH);
   localparam logic [CNT_W-1:0]   TIMEOUT_C  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
   localparam logic [MATCH_W-1:0] LOCK_C     = MATCH_W'(LOCK_COUNT);

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   state_t             state, state_d;
   logic               q;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [CNT_W-1:0]   high_len, high_len_d;
   logic [MATCH_W-1:0] match_cnt, match_cnt_d;
   logic [CNT_W-1:0]   period_d, high_d;
   logic               valid_d, locked_d, err_d;

   logic               rise_c, fall_c;
   logic [MATCH_W-1:0] match_inc_c;

   assign rise_c      = freq_in & ~q;
   assign fall_c      = ~freq_in & q;
   assign match_inc_c = (match_cnt == LOCK_C) ? match_cnt : match_cnt + MATCH_W'(1);

   // State and measurement registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         q          <= 1'b1;
         cnt        <= '0;
         high_len   <= '0;
         match_cnt  <= '0;
         period_out <= '0;
         high_out   <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_d;
         q          <= freq_in;
         cnt        <= cnt_d;
         high_len   <= high_len_d;
         match_cnt  <= match_cnt_d;
         period_out <= period_d;
         high_out   <= high_d;
         meas_valid <= valid_d;
         locked     <= locked_d;
         err        <= err_d;
      end
   end

   // Next-state, counter and report logic
   always_comb begin
      state_d     = state;
      cnt_d       = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      high_len_d  = high_len;
      match_cnt_d = match_cnt;
      period_d    = period_out;
      high_d      = high_out;
      valid_d     = 1'b0;
      locked_d    = locked;
      err_d       = 1'b0;

      if (rise_c) cnt_d = CNT_W'(1);

      case (state)
         IDLE: begin
            if (rise_c) state_d = MEASURE;
         end
         MEASURE: begin
            if (fall_c) high_len_d = cnt;
            if (rise_c) begin
               period_d = cnt;
               high_d   = high_len;
               valid_d  = 1'b1;
               if (cnt == DIV_C && high_len == EXP_HIGH_C) begin
                  match_cnt_d = match_inc_c;
                  if (match_inc_c == LOCK_C) locked_d = 1'b1;
               end else begin
                  match_cnt_d = '0;
                  locked_d    = 1'b0;
                  err_d       = 1'b1;
               end
            end else if (cnt == TIMEOUT_C) begin
               // Stalled input: drop lock and wait for a fresh rise
               err_d       = 1'b1;
               locked_d    = 1'b0;
               match_cnt_d = '0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_freq_div_monitor.sv
// Bench for freq_div_monitor: scenario table, hand-written corner sequences and
// random waveforms, all checked cycle by cycle against an event-level model.
module tb_freq_div_monitor;

   localparam int unsigned DIV        = 6;
   localparam int unsigned EXP_HIGH   = 3;
   localparam int unsigned LOCK_COUNT = 4;
   localparam int unsigned TIMEOUT    = 24;
   localparam int unsigned CNT_W      = 8;

   logic             clk;
   logic             rst;
   logic             freq_in;
   logic [CNT_W-1:0] period_out;
   logic [CNT_W-1:0] high_out;
   logic             meas_valid;
   logic             locked;
   logic             err;

   freq_div_monitor #(
      .DIV(DIV), .EXP_HIGH(EXP_HIGH), .LOCK_COUNT(LOCK_COUNT),
      .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .freq_in(freq_in),
      .period_out(period_out), .high_out(high_out),
      .meas_valid(meas_valid), .locked(locked), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int tick_n = 0;

   // Reference model: tracks edge times as cycle indices
   bit m_prev = 1'b1;
   bit m_meas = 1'b0;
   int m_rise_at = 0;
   int m_high = 0;
   int m_matches = 0;
   int e_period = 0;
   int e_high = 0;
   bit e_valid = 1'b0;
   bit e_locked = 1'b0;
   bit e_err = 1'b0;

   typedef struct {
      int hi;
      int lo;
      int n;
      int exp_period;
      int exp_high;
      bit exp_err;
      bit exp_locked;
   } vec_t;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h (tick %0d)", name, act, exp, tick_n);
      end
   endtask

   task automatic model_step(input bit r, input bit f);
      bit rise, fall;
      int age;
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (r) begin
         m_prev = 1'b1; m_meas = 1'b0; m_high = 0; m_matches = 0;
         e_period = 0; e_high = 0; e_locked = 1'b0;
         return;
      end
      rise = f && !m_prev;
      fall = !f && m_prev;
      age  = tick_n - m_rise_at;
      if (!m_meas) begin
         if (rise) begin
            m_meas = 1'b1;
            m_rise_at = tick_n;
         end
      end else if (rise) begin
         e_period = age;
         e_high   = m_high;
         e_valid  = 1'b1;
         if (age == int'(DIV) && m_high == int'(EXP_HIGH)) begin
            if (m_matches < int'(LOCK_COUNT)) m_matches++;
            if (m_matches == int'(LOCK_COUNT)) e_locked = 1'b1;
         end else begin
            m_matches = 0;
            e_locked  = 1'b0;
            e_err     = 1'b1;
         end
         m_rise_at = tick_n;
      end else begin
         if (fall) m_high = age;
         if (age == int'(TIMEOUT)) begin
            e_err = 1'b1; e_locked = 1'b0; m_matches = 0; m_meas = 1'b0;
         end
      end
      m_prev = f;
   endtask

   // One clk cycle: drive on negedge, model at posedge, compare just after
   task automatic tick(input bit r, input bit f);
      @(negedge clk);
      rst = r;
      freq_in = f;
      @(posedge clk);
      tick_n++;
      model_step(r, f);
      #1;
      check("cycle", 32'({meas_valid, locked, err, period_out, high_out}),
            32'({e_valid, e_locked, e_err, CNT_W'(e_period), CNT_W'(e_high)}));
   endtask

   task automatic wave(input int hi, input int lo);
      for (int c = 0; c < hi + lo; c++) tick(1'b0, c < hi);
   endtask

   initial begin
      vec_t vecs[4];
      int last_start, err_tick, n_err, nv, lock_idx;

      vecs[0] = '{hi: 3, lo: 3, n: 8, exp_period: 6, exp_high: 3, exp_err: 1'b0, exp_locked: 1'b1};
      vecs[1] = '{hi: 3, lo: 2, n: 6, exp_period: 5, exp_high: 3, exp_err: 1'b1, exp_locked: 1'b0};
      vecs[2] = '{hi: 4, lo: 2, n: 6, exp_period: 6, exp_high: 4, exp_err: 1'b1, exp_locked: 1'b0};
      vecs[3] = '{hi: 3, lo: 3, n: 6, exp_period: 6, exp_high: 3, exp_err: 1'b0, exp_locked: 1'b1};

      rst = 1'b1;
      freq_in = 1'b0;
      last_start = 0;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      check("reset_state", 32'({meas_valid, locked, err, period_out, high_out}), 32'(0));
      tick(1'b0, 1'b0);

      // Table: each report after the first in a scenario covers that scenario's shape
      for (int v = 0; v < 4; v++) begin
         for (int p = 0; p < vecs[v].n; p++) begin
            for (int c = 0; c < vecs[v].hi + vecs[v].lo; c++) begin
               tick(1'b0, c < vecs[v].hi);
               if (c == 0) begin
                  last_start = tick_n;
                  if (p > 0)
                     check($sformatf("vec%0d_report", v),
                           32'({meas_valid, err, period_out, high_out}),
                           32'({1'b1, vecs[v].exp_err, CNT_W'(vecs[v].exp_period),
                                CNT_W'(vecs[v].exp_high)}));
               end
            end
         end
         check($sformatf("vec%0d_locked_end", v), 32'(locked), 32'(vecs[v].exp_locked));
      end

      // Stall low after lock: one err exactly TIMEOUT cycles after the last rise
      err_tick = -1;
      n_err = 0;
      for (int i = 0; i < 30; i++) begin
         tick(1'b0, 1'b0);
         if (err) begin
            n_err++;
            if (err_tick < 0) err_tick = tick_n;
         end
      end
      check("timeout_delay", 32'(err_tick - last_start), 32'(TIMEOUT));
      check("timeout_pulses", 32'(n_err), 32'(1));
      check("timeout_unlocked", 32'(locked), 32'(0));
      check("timeout_period_hold", 32'({period_out, high_out}), 32'({CNT_W'(6), CNT_W'(3)}));
      nv = 0;
      for (int c = 0; c < 6; c++) begin
         tick(1'b0, c < 3);
         if (meas_valid) nv++;
      end
      check("idle_rise_no_report", 32'(nv), 32'(0));
      tick(1'b0, 1'b1);
      check("post_idle_report", 32'({meas_valid, err, locked, period_out, high_out}),
            32'({3'b100, CNT_W'(6), CNT_W'(3)}));
      for (int c = 1; c < 6; c++) tick(1'b0, c < 3);

      // Reset mid-period while locked, input high across reset release
      for (int p = 0; p < 4; p++) wave(3, 3);
      check("pre_reset_locked", 32'(locked), 32'(1));
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      check("reset_mid_outputs", 32'({meas_valid, locked, err, period_out, high_out}), 32'(0));
      tick(1'b0, 1'b1);
      check("release_high_no_rise", 32'({meas_valid, err}), 32'(0));
      for (int c = 0; c < 3; c++) tick(1'b0, 1'b0);
      nv = 0;
      lock_idx = 0;
      for (int p = 0; p < 6; p++) begin
         for (int c = 0; c < 6; c++) begin
            tick(1'b0, c < 3);
            if (meas_valid) begin
               nv++;
               if (locked && lock_idx == 0) lock_idx = nv;
            end
         end
      end
      check("post_reset_reports", 32'(nv), 32'(5));
      check("relock_index", 32'(lock_idx), 32'(LOCK_COUNT));

      // Random waveforms: clean periods, odd shapes, stalls and resets
      for (int i = 0; i < 300; i++) begin
         int kind;
         kind = int'($urandom_range(0, 10));
         if (kind <= 5) wave(3, 3);
         else if (kind == 6) wave(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
         else if (kind == 7) wave(0, int'($urandom_range(18, 30)));
         else if (kind == 8) wave(int'($urandom_range(18, 30)), 0);
         else if (kind == 9) begin
            for (int k = 0; k < int'($urandom_range(1, 2)); k++) tick(1'b1, 1'($urandom_range(0, 1)));
         end else wave(int'($urandom_range(1, 3)), int'($urandom_range(2, 4)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
